// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage valid/ready rounding back end for the FP adder datapath
package fp_pkg;

    typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    function automatic int exp_bits(input fp_format_e f);
        return (f == FP16) ? 5 : (f == FP64) ? 11 : 8;
    endfunction

    function automatic int mant_bits(input fp_format_e f);
        return (f == FP16) ? 10 : (f == FP64) ? 52 : 23;
    endfunction

    function automatic int fp_bits(input fp_format_e f);
        return 1 + exp_bits(f) + mant_bits(f);
    endfunction

    // unrounded bundle = {u_result, rs, round_en, invalid, exp_cout}
    function automatic int uround_bits(input fp_format_e f);
        return fp_bits(f) + 6;
    endfunction

endpackage

module fp_round_pipe
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32,
    localparam int EXP_WIDTH  = exp_bits(FP_FORMAT),
    localparam int MANT_WIDTH = mant_bits(FP_FORMAT),
    localparam int FP_WIDTH   = fp_bits(FP_FORMAT),
    localparam int URND_WIDTH = uround_bits(FP_FORMAT)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [URND_WIDTH-1:0] urnd_result_i,
    input  roundmode_e            rnd_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [FP_WIDTH-1:0]   result_o,
    output logic [4:0]            flags_o
);

    typedef struct packed {
        logic [FP_WIDTH-1:0] u_result;
        logic [1:0]          rs;
        logic                round_en;
        logic                invalid;
        logic [1:0]          exp_cout;
    } uround_res_t;

    uround_res_t urnd, s1_b;
    roundmode_e  rm_in, s1_rnd;
    logic        s1_valid, s2_valid, s1_adv, inc_in, s1_inc, rs_in;

    assign urnd    = urnd_result_i;
    assign rm_in   = (rnd_i > RMM) ? RNE : rnd_i;
    assign rs_in   = |urnd.rs;
    assign s1_adv  = !s2_valid | ready_i;
    assign ready_o = !s1_valid | s1_adv;
    assign valid_o = s2_valid;

    assign inc_in = (rm_in == RTZ) ? 1'b0 :
                    (rm_in == RDN) ? rs_in & urnd.u_result[FP_WIDTH-1] :
                    (rm_in == RUP) ? rs_in & !urnd.u_result[FP_WIDTH-1] :
                    (rm_in == RMM) ? urnd.rs[1] :
                    urnd.rs[1] & (urnd.rs[0] | urnd.u_result[0]);

    // stage 1: capture the bundle, normalised mode and round increment on accept
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_b     <= '0;
            s1_rnd   <= RNE;
            s1_inc   <= 1'b0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_b   <= urnd;
                s1_rnd <= rm_in;
                s1_inc <= inc_in;
            end
        end
    end

    logic                  sign, exp_ones, mant_nz, is_nan, nx, ovf, to_inf, of_nx, tiny;
    logic [EXP_WIDTH-1:0]  exp_f, sum_exp;
    logic [MANT_WIDTH-1:0] mant_f;
    logic [FP_WIDTH-2:0]   sum, sat_mag;
    logic [FP_WIDTH-1:0]   res_d;
    logic [4:0]            flags_d;

    localparam logic [FP_WIDTH-1:0] QNAN    = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic [FP_WIDTH-2:0] INF_MAG = {{EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    localparam logic [FP_WIDTH-2:0] MAX_MAG = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};

    assign {sign, exp_f, mant_f} = s1_b.u_result;
    assign sum      = s1_b.u_result[FP_WIDTH-2:0] + (FP_WIDTH-1)'(s1_inc);
    assign sum_exp  = sum[FP_WIDTH-2:MANT_WIDTH];
    assign exp_ones = &exp_f;
    assign mant_nz  = |mant_f;
    assign is_nan   = exp_ones & mant_nz;
    assign nx       = |s1_b.rs;
    // an exact infinity with nothing shifted out is the one saturating input that passes through
    assign ovf      = ((s1_b.exp_cout == 2'b01) | exp_ones | (&sum_exp)) & !(exp_ones & !mant_nz & !nx);
    assign to_inf   = (s1_rnd == RTZ) ? 1'b0 : (s1_rnd == RUP) ? !sign : (s1_rnd == RDN) ? sign : 1'b1;
    assign of_nx    = nx | (|s1_b.exp_cout);
    assign tiny     = s1_inc & ((s1_rnd == RUP) | (s1_rnd == RDN));
    assign sat_mag  = to_inf ? INF_MAG : MAX_MAG;

    assign res_d = (s1_b.invalid | is_nan) ? QNAN :
                   !s1_b.round_en          ? s1_b.u_result :
                   ovf                     ? {sign, sat_mag} :
                   s1_b.exp_cout[1]        ? {sign, (FP_WIDTH-1)'(tiny)} :
                   {sign, sum};

    assign flags_d = s1_b.invalid                ? 5'b10000 :
                     (is_nan | !s1_b.round_en)   ? 5'b00000 :
                     ovf                         ? {2'b00, of_nx, 1'b0, of_nx} :
                     s1_b.exp_cout[1]            ? 5'b00011 :
                     {3'b000, ~|sum_exp & nx, nx};

    // stage 2: register the rounded result; holds while the consumer stalls
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s2_valid <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_o <= res_d;
                flags_o  <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: scoreboard bench for fp_round_pipe with random and directed bundles
module tb_fp_round_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        ready_o, valid_o;
    logic [37:0] urnd = '0;
    roundmode_e  rnd = RNE;
    logic [31:0] result_o;
    logic [4:0]  flags_o;

    int          checks = 0;
    int          passes = 0;
    logic [36:0] exp_q[$];
    logic [36:0] dir_exp = '0;
    bit          dir_on = 1'b0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    fp_round_pipe #(.FP_FORMAT(FP32)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .urnd_result_i(urnd), .rnd_i(rnd), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .flags_o(flags_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // IEEE-754 FP32 rounding rules applied directly to the bundle fields
    function automatic logic [36:0] model(input logic [37:0] b, input logic [2:0] rm_raw);
        logic [31:0] u = b[37:6];
        int unsigned mode = (rm_raw > 3'd4) ? 0 : int'(rm_raw);
        bit sg = u[31];
        bit r = b[5];
        bit s = b[4];
        bit nx = b[5] | b[4];
        logic [1:0] ec = b[1:0];
        bit up;
        bit to_inf;
        int unsigned mag;
        case (mode)
            0: up = r && (s || u[0]);
            1: up = 1'b0;
            2: up = nx && sg;
            3: up = nx && !sg;
            default: up = r;
        endcase
        if (b[2]) return {32'h7FC00000, 5'b10000};
        if (u[30:23] == 8'hFF && u[22:0] != 0) return {32'h7FC00000, 5'b00000};
        if (!b[3]) return {u, 5'b00000};
        mag = 32'(u[30:0]) + 32'(up);
        if ((ec == 2'b01 || u[30:23] == 8'hFF || mag >= 32'h7F800000) && !(u[30:0] == 31'h7F800000 && !nx)) begin
            to_inf = mode == 0 || mode == 4 || (mode == 3 && !sg) || (mode == 2 && sg);
            return {sg, to_inf ? 31'h7F800000 : 31'h7F7FFFFF, (nx || ec != 0) ? 5'b00101 : 5'b00000};
        end
        if (ec[1]) return {sg, 31'(up && (mode == 2 || mode == 3)), 5'b00011};
        return {sg, mag[30:0], 3'b000, mag < 32'h00800000 && nx, nx};
    endfunction

    // scoreboard push on every accepted bundle
    always @(negedge clk)
        if (!reset_i && valid_i && ready_o)
            exp_q.push_back(dir_on ? dir_exp : model(urnd, rnd));

    logic        held = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_flags;

    // monitor: pop on every emitted result, and check that stalled outputs hold
    always @(negedge clk) begin
        logic [36:0] e;
        if (reset_i) held = 1'b0;
        else begin
            if (held) begin
                check("stall_valid", valid_o, 1);
                check("stall_result", result_o, held_res);
                check("stall_flags", flags_o, held_flags);
            end
            held = valid_o && !ready_i;
            held_res = result_o;
            held_flags = flags_o;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) check("unexpected_output", result_o, 64'hDEAD_0000_0000);
                else begin
                    e = exp_q.pop_front();
                    check("result", result_o, e[36:5]);
                    check("flags", flags_o, e[4:0]);
                end
            end
        end
    end

    task automatic send(input logic [31:0] u, input logic [1:0] rs, input bit ren, input bit inv,
                        input logic [1:0] ec, input logic [2:0] rm, input logic [36:0] ev, input bit use_ev);
        bit done = 1'b0;
        urnd = {u, rs, ren, inv, ec};
        rnd = roundmode_e'(rm);
        dir_exp = ev;
        dir_on = use_ev;
        valid_i = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = ready_o;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        dir_on = 1'b0;
        check("accept_timeout", done, 1);
    endtask

    task automatic send_rand();
        logic [7:0]  e;
        logic [22:0] m;
        logic [1:0]  ec;
        int          k;
        k = $urandom_range(0, 5);
        e = (k == 0) ? 8'h00 : (k == 1) ? 8'h01 : (k == 2) ? 8'hFE : (k == 3) ? 8'hFF : 8'($urandom);
        k = $urandom_range(0, 3);
        m = (k == 0) ? 23'h7FFFFF : (k == 1) ? 23'h0 : 23'($urandom);
        k = $urandom_range(0, 9);
        ec = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b00;
        send({1'($urandom), e, m}, 2'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
             ec, 3'($urandom_range(0, 7)), '0, 1'b0);
    endtask

    task automatic latency_probe(input logic [31:0] u, input logic [1:0] rs, input logic [2:0] rm, input logic [36:0] ev);
        send(u, rs, 1'b1, 1'b0, 2'b00, rm, ev, 1'b1);
        check("latency_not_early", valid_o, 0);
        @(posedge clk);
        #1;
        check("latency_two", valid_o, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("reset_valid", valid_o, 0);
        check("reset_result", result_o, 0);
        check("reset_flags", flags_o, 0);
        @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", ready_o, 1);

        latency_probe(32'h3F800000, 2'b10, 3'd0, {32'h3F800000, 5'b00001});
        send(32'h3F800001, 2'b10, 1, 0, 2'b00, 3'd0, {32'h3F800002, 5'b00001}, 1);
        send(32'h3F800001, 2'b10, 1, 0, 2'b00, 3'd1, {32'h3F800001, 5'b00001}, 1);
        send(32'h3F7FFFFF, 2'b11, 1, 0, 2'b00, 3'd3, {32'h3F800000, 5'b00001}, 1);
        send(32'h7F7FFFFF, 2'b11, 1, 0, 2'b00, 3'd0, {32'h7F800000, 5'b00101}, 1);
        send(32'h7F7FFFFF, 2'b11, 1, 0, 2'b00, 3'd1, '0, 0);
        send(32'hFF7FFFFF, 2'b11, 1, 0, 2'b00, 3'd3, {32'hFF7FFFFF, 5'b00001}, 1);
        send(32'h7F800000, 2'b00, 1, 1, 2'b00, 3'd0, {32'h7FC00000, 5'b10000}, 1);
        send(32'h00000005, 2'b10, 0, 0, 2'b00, 3'd0, {32'h00000005, 5'b00000}, 1);
        send(32'h00000000, 2'b01, 1, 0, 2'b10, 3'd3, {32'h00000001, 5'b00011}, 1);
        send(32'h00000000, 2'b01, 1, 0, 2'b10, 3'd0, {32'h00000000, 5'b00011}, 1);
        send(32'h7FC00001, 2'b00, 1, 0, 2'b00, 3'd0, {32'h7FC00000, 5'b00000}, 1);
        send(32'h7F800000, 2'b00, 1, 0, 2'b00, 3'd0, {32'h7F800000, 5'b00000}, 1);
        send(32'h3F800001, 2'b10, 1, 0, 2'b00, 3'd6, {32'h3F800002, 5'b00001}, 1);
        drain();

        ready_i = 1'b0;
        send_rand();
        send_rand();
        check("ready_low_when_full", ready_o, 0);
        fork
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join_none
        send_rand();
        send_rand();
        drain();

        rand_rdy = 1'b1;
        fork
            begin
                while (rand_rdy) begin
                    @(posedge clk);
                    #1 ready_i = $urandom_range(0, 3) != 0;
                end
                ready_i = 1'b1;
            end
        join_none
        for (int i = 0; i < 300; i++) send_rand();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 ready_i = 1'b1;
        drain();

        ready_i = 1'b0;
        send_rand();
        send_rand();
        #2 reset_i = 1'b1;
        #1;
        check("async_reset_valid", valid_o, 0);
        check("async_reset_result", result_o, 0);
        check("async_reset_flags", flags_o, 0);
        exp_q.delete();
        ready_i = 1'b1;
        @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("no_stale_valid", valid_o, 0);
        check("ready_after_mid_reset", ready_o, 1);
        latency_probe(32'h3F800001, 2'b10, 3'd0, {32'h3F800002, 5'b00001});
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
